// File: rtl/a5_1_byte_ctrl.sv
// Byte-serial stream-cipher controller: gathers 8 keystream bits per byte and XORs them with pixels.
// Optional A5_1_WARMUP_EN inserts a 100-cycle discard phase after the key load.
module a5_1_byte_ctrl #(
    parameter int unsigned NUM_BYTES = 65536,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      key,
    input  logic             start,
    output logic             ks_load,
    output logic [63:0]      ks_key,
    output logic             ks_step,
    input  logic             ks_bit,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [7:0]       enc_out,
    output logic             enc_valid,
    input  logic             enc_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_idx
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StWarmup, StGather, StXfer, StOut, StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_BYTES - 1);

    state_e     state_q;
    logic [7:0] ks_byte_q;
    logic [2:0] bit_cnt_q;
`ifdef A5_1_WARMUP_EN
    logic [6:0] warm_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ks_byte_q <= 8'h00;
            bit_cnt_q <= 3'd0;
`ifdef A5_1_WARMUP_EN
            warm_cnt_q <= 7'd0;
`endif
            ks_load   <= 1'b0;
            ks_key    <= 64'h0;
            ks_step   <= 1'b0;
            pix_ready <= 1'b0;
            enc_out   <= 8'h00;
            enc_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            byte_idx  <= '0;
        end else begin
            ks_load <= 1'b0;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        ks_load <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                StLoad: begin
                    ks_key    <= key;
                    byte_idx  <= '0;
                    bit_cnt_q <= 3'd0;
                    ks_step   <= 1'b1;
`ifdef A5_1_WARMUP_EN
                    warm_cnt_q <= 7'd0;
                    state_q    <= StWarmup;
`else
                    state_q <= StGather;
`endif
                end
                StWarmup: begin
`ifdef A5_1_WARMUP_EN
                    // ks_step stays high; the warmup bits are simply not captured
                    if (warm_cnt_q == 7'd99) begin
                        state_q <= StGather;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + 7'd1;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StGather: begin
                    ks_byte_q[bit_cnt_q] <= ks_bit;
                    bit_cnt_q            <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q   <= StXfer;
                        ks_step   <= 1'b0;
                        pix_ready <= 1'b1;
                    end
                end
                StXfer: begin
                    if (pix_valid) begin
                        enc_out   <= pix_in ^ ks_byte_q;
                        enc_valid <= 1'b1;
                        pix_ready <= 1'b0;
                        state_q   <= StOut;
                    end
                end
                StOut: begin
                    if (enc_ready) begin
                        enc_valid <= 1'b0;
                        if (byte_idx == LastIdx) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            byte_idx  <= byte_idx + 1'b1;
                            bit_cnt_q <= 3'd0;
                            ks_step   <= 1'b1;
                            state_q   <= StGather;
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_a5_1_byte_ctrl.sv
// Scoreboard bench for a5_1_byte_ctrl: a bit-array generator stub feeds the DUT and a
// model computes each encrypted byte from the stream position it must consume.
module tb_a5_1_byte_ctrl;

    localparam int NB = 4;
`ifdef A5_1_WARMUP_EN
    localparam int WARM = 100;
`else
    localparam int WARM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, ks_load, ks_step, ks_bit;
    logic [63:0] key, ks_key;
    logic [7:0]  pix_in, enc_out;
    logic        pix_valid, pix_ready, enc_valid, enc_ready, busy, done;
    logic [15:0] byte_idx;

    a5_1_byte_ctrl #(.NUM_BYTES(NB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .key(key), .start(start), .ks_load(ks_load), .ks_key(ks_key),
        .ks_step(ks_step), .ks_bit(ks_bit), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .enc_out(enc_out), .enc_valid(enc_valid),
        .enc_ready(enc_ready), .busy(busy), .done(done), .byte_idx(byte_idx)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, t_done = 0, steps = 0, done_cnt = 0, run = 0, first_run = -1;
    int gen_idx = 0, ready_mode = 0;
    bit armed = 0;
    logic stream [0:511];

    typedef struct { logic [7:0] data; int idx; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Keystream byte b of a frame: the 8 stream bits following warmup and earlier bytes, LSB first
    function automatic logic [7:0] kbyte(input int b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = stream[WARM + 8 * b + j];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ks_load) gen_idx <= 0;
        else if (ks_step) gen_idx <= gen_idx + 1;
    end
    assign ks_bit = stream[gen_idx % 512];

    initial forever begin
        @(posedge clk); #1;
        if (ready_mode == 0) enc_ready = 1'b1;
        else if (ready_mode == 1) enc_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor and protocol invariants
    initial begin : monitor
        logic prev_hold;
        logic [7:0] prev_out;
        exp_t e;
        prev_hold = 1'b0;
        prev_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (enc_valid && enc_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output: got 0x%0h with no expected byte", enc_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("enc_out", 64'(enc_out), 64'(e.data));
                    chk("out_byte_idx", 64'(byte_idx), 64'(e.idx));
                end
            end
            if (pix_ready || enc_valid) chk("ready_valid_excl", 64'(pix_ready && enc_valid), 0);
            if (ks_step) chk("step_only_gather", 64'(pix_ready | enc_valid | ks_load), 0);
            if (prev_hold && enc_valid) chk("enc_out_stable", 64'(enc_out), 64'(prev_out));
            prev_hold = enc_valid && !enc_ready;
            prev_out  = enc_out;

            if (ks_load) begin
                steps = 0; armed = 1; run = 0; done_cnt = 0;
            end else begin
                if (ks_step) steps++;
                if (armed) begin
                    if (pix_ready) begin first_run = run; armed = 0; end
                    else if (ks_step) run++;
                    else run = 0;
                end
            end
            if (done) begin done_cnt++; t_done = cyc; end
        end
    end

    task automatic start_frame(input logic [63:0] k);
        @(posedge clk); #1;
        key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; t0 = cyc;
        @(negedge clk);
        chk("ks_load_pulse", 64'(ks_load), 1);
        chk("busy_in_load", 64'(busy), 1);
        @(negedge clk);
        chk("ks_key", ks_key, k);
        chk("load_byte_idx", 64'(byte_idx), 0);
        @(posedge clk); #1;
        key = ~k;
    endtask

    task automatic send_byte(input logic [7:0] p, input int b, input int delay);
        bit ok = 0;
        exp_t e;
        repeat (delay) begin @(posedge clk); #1; end
        pix_in = p; pix_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pix_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL pix_ready_timeout: got 0 expected 1 (byte %0d)", b);
        end else begin
            e.data = p ^ kbyte(b); e.idx = b;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL done_timeout: got 0 expected 1");
        end
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 0);
        chk("done_one_cycle", 64'(done), 0);
        chk("byte_idx_hold", 64'(byte_idx), NB - 1);
        chk("queue_drained", 64'(exp_q.size()), 0);
    endtask

    task automatic run_frame(input logic [63:0] k, input logic [31:0] pix, input int dmax);
        start_frame(k);
        for (int b = 0; b < NB; b++)
            send_byte(pix[8 * b +: 8], b, int'($urandom_range(0, dmax)));
        wait_done();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ks_load"}, 64'(ks_load), 0);
        chk({tag, "_ks_step"}, 64'(ks_step), 0);
        chk({tag, "_ks_key"}, ks_key, 0);
        chk({tag, "_pix_ready"}, 64'(pix_ready), 0);
        chk({tag, "_enc_out"}, 64'(enc_out), 0);
        chk({tag, "_enc_valid"}, 64'(enc_valid), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_byte_idx"}, 64'(byte_idx), 0);
    endtask

    initial begin
        logic [63:0] k;
        bit ok;
        rst = 1'b1; start = 1'b0; key = '0; pix_in = '0; pix_valid = 1'b0; enc_ready = 1'b1;
        for (int i = 0; i < 512; i++) stream[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Constant-one generator: 0x5A -> 0xA5
        for (int i = 0; i < 512; i++) stream[i] = 1'b1;
        run_frame(64'h0123_4567_89AB_CDEF, 32'h5A5A_5A5A, 0);

        // Alternating 1,0,...: 0x00 -> 0x55, 0xFF -> 0xAA
        for (int i = 0; i < 512; i++) stream[i] = (i % 2 == 0);
        run_frame(64'hDEAD_BEEF_0000_0001, 32'hFF00_FF00, 0);

        // Output stalled five cycles on the first byte
        for (int i = 0; i < 512; i++) stream[i] = 1'($urandom_range(0, 1));
        start_frame({$urandom, $urandom});
        ready_mode = 2; enc_ready = 1'b0;
        send_byte(8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_enc_valid", 64'(enc_valid), 1);
            chk("stall_enc_out", 64'(enc_out), 64'(8'h3C ^ kbyte(0)));
            chk("stall_ks_step", 64'(ks_step), 0);
            chk("stall_pix_ready", 64'(pix_ready), 0);
        end
        @(posedge clk); #1;
        enc_ready = 1'b1; ready_mode = 0;
        for (int b = 1; b < NB; b++) send_byte(8'(b * 37), b, 0);
        wait_done();

        // Back-to-back throughput
        for (int i = 0; i < 512; i++) stream[i] = 1'($urandom_range(0, 1));
        k = {$urandom, $urandom};
        run_frame(k, $urandom, 0);
        chk("start_to_done", 64'(t_done - t0), 41 + WARM);
        chk("ks_step_total", 64'(steps), 32 + WARM);
        chk("done_count", 64'(done_cnt), 1);
        chk("steps_before_ready", 64'(first_run), 8 + WARM);
        chk("ks_key_held", ks_key, k);

        // Random stalls on both handshakes
        ready_mode = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 512; i++) stream[i] = 1'($urandom_range(0, 1));
            run_frame({$urandom, $urandom}, $urandom, 3);
            chk("rand_done_count", 64'(done_cnt), 1);
        end
        ready_mode = 0;

        // Reset on the 4th gather cycle of the second byte
        for (int i = 0; i < 512; i++) stream[i] = 1'($urandom_range(0, 1));
        start_frame({$urandom, $urandom});
        send_byte(8'($urandom), 0, 0);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (byte_idx == 16'd1 && ks_step) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL second_gather_timeout: got 0 expected 1");
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        exp_q.delete();
        run_frame({$urandom, $urandom}, $urandom, 1);

        // Reset wins over start
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 64'(busy), 0);
        chk("rst_prio_load", 64'(ks_load), 0);
        @(negedge clk);
        chk("rst_prio_busy2", 64'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a5_1_byte_ctrl.md
A5_1_BYTE_CTRL -- requirements
Module: a5_1_byte_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 65536: bytes per frame, legal range 1..65536.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of byte_idx.
REQ-003 The block SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port key  in  64  secret key, sampled only in LOAD.
REQ-006 The block SHALL have port start  in  1  one-cycle frame request.
REQ-007 The block SHALL have port ks_load  out  1  load strobe to the keystream generator.
REQ-008 The block SHALL have port ks_key  out  64  key to the generator, registered copy of key.
REQ-009 The block SHALL have port ks_step  out  1  generator advance-enable; the generator holds state when low.
REQ-010 The block SHALL have port ks_bit  in  1  current generator keystream bit.
REQ-011 The block SHALL have port pix_in  in  8  plaintext pixel byte.
REQ-012 The block SHALL have port pix_valid / pix_ready  in / out  1  input handshake.
REQ-013 The block SHALL have port enc_out  out  8  encrypted byte.
REQ-014 The block SHALL have port enc_valid / enc_ready  out / in  1  output handshake.
REQ-015 The block SHALL have port busy  out  1  high in any state other than IDLE.
REQ-016 The block SHALL have port done  out  1  one-cycle end-of-frame pulse.
REQ-017 The block SHALL have port byte_idx  out  CNT_W  index of the current byte within the frame.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, WARMUP, GATHER, XFER, OUT, DONE.
REQ-019 IDLE: start=1 -> LOAD; start SHALL be ignored in every other state.
REQ-020 LOAD (1 cycle): ks_load=1, ks_key<=key, byte_idx<=0; next state is WARMUP if the macro is defined, else GATHER.
REQ-021 GATHER (exactly 8 cycles): ks_step=1 each cycle; on cycle j (0..7), ks_byte[j]<=ks_bit, so the first bit after load goes to the LSB; then -> XFER.
REQ-022 XFER: pix_ready=1 and ks_step=0; on pix_valid=1, enc_out<=pix_in^ks_byte, enc_valid<=1, -> OUT. With pix_valid=0 the block SHALL wait indefinitely.
REQ-023 OUT: enc_valid=1; enc_out SHALL be held stable while enc_ready=0.
REQ-024 OUT, on enc_ready=1: enc_valid<=0; if byte_idx==NUM_BYTES-1 -> DONE, else byte_idx++ -> GATHER.
REQ-025 DONE (1 cycle): done=1 -> IDLE; byte_idx SHALL hold its last value until the next LOAD.
REQ-026 ks_step SHALL be asserted only in GATHER and WARMUP, so that no keystream bit is skipped or reused under any stall.
REQ-027 pix_ready and enc_valid SHALL never be high in the same cycle.
REQ-028 Minimum throughput SHALL be 10 cycles per byte (8 GATHER + 1 XFER + 1 OUT).

Reset
REQ-029 rst=1 SHALL force the IDLE state in any state, including mid-frame, and discard any partial ks_byte and pending output.
REQ-030 Reset values: ks_load=0, ks_step=0, ks_key=0, pix_ready=0, enc_out=0x00, enc_valid=0, busy=0, done=0, byte_idx=0.
REQ-031 rst SHALL take priority over start in the same cycle.

Configuration
REQ-032 With macro A5_1_WARMUP_EN defined, WARMUP SHALL last 100 cycles with ks_step=1, with the bits discarded, then -> GATHER.
REQ-033 Without A5_1_WARMUP_EN, WARMUP SHALL be unreachable and LOAD SHALL go directly to GATHER.

Verification
REQ-034 Stub generator ks_bit=1 constant, NUM_BYTES=1, pix_in=0x5A -> enc_out=0xA5, then done pulse, then busy=0.
REQ-035 Stub bit stream 1,0,1,0,... with pix_in=0x00 -> enc_out=0x55; a second byte with pix_in=0xFF -> enc_out=0xAA.
REQ-036 enc_ready held low 5 cycles in OUT -> enc_out stable, ks_step=0 and pix_ready=0 throughout.
REQ-037 NUM_BYTES=4 with all handshakes immediate -> 32 ks_step cycles total, byte_idx runs 0..3, done exactly once, 41 cycles from start to done (macro off).
REQ-038 rst pulsed on the 4th GATHER cycle of byte 2 -> next cycle all outputs at reset values; a new start then restarts from LOAD with byte_idx=0.
REQ-039 A5_1_WARMUP_EN defined -> 108 consecutive ks_step cycles after ks_load before the first pix_ready.
